// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 sequential demultiplexer.
// Optional round-robin select is enabled by defining DEMUX_ROUNDROBIN_EN.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int W_DEF = 8;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: a single-entry holding register with an EMPTY/FULL FSM.
// A load in the FULL state is only issued by the top when the sink also consumes.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  chan_state_t  state_q, state_d;
  logic [W-1:0] data_q, data_d;

  // Next state and data: load wins over consume so a same-cycle reload stays FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (load_i) begin
          state_d = FULL;
          data_d  = d_i;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (load_i) begin
          state_d = FULL;
          data_d  = d_i;
        end else if (ready_i) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
        data_d  = {W{1'b0}};
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);

endmodule

// File: rtl/demux_1by4_seq.sv
// 1-to-4 demultiplexer with per-channel holding registers and valid/ready flow control.
// Define DEMUX_ROUNDROBIN_EN to ignore s and steer beats with an internal round-robin pointer.
module demux_1by4_seq
  import demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     i,
  input  logic [1:0]       s,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [4*W-1:0]   y,
  output logic [NCH-1:0]   y_valid,
  input  logic [NCH-1:0]   y_ready
);

  sel_t           sel_s;
  logic           accept_s;
  logic [NCH-1:0] valid_s;
  logic [NCH-1:0] load_s;

`ifdef DEMUX_ROUNDROBIN_EN
  sel_t ptr_q, ptr_d;

  // Pointer advances only on an accepted beat, so a stalled channel is never skipped.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      ptr_d = sel_t'(ptr_q + 2'd1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign sel_s = ptr_q;
`else
  assign sel_s = s;
`endif

  assign i_ready  = ~rst & (~valid_s[sel_s] | y_ready[sel_s]);
  assign accept_s = i_valid & i_ready;

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    assign load_s[n] = accept_s & (sel_s == sel_t'(n));

    demux_chan_reg #(
      .W (W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_s[n]),
      .d_i     (i),
      .ready_i (y_ready[n]),
      .data_o  (y[n*W +: W]),
      .valid_o (valid_s[n])
    );
  end

  assign y_valid = valid_s;

endmodule

// File: tb/tb_demux_1by4_seq.sv
// Directed and randomised self-checking bench for demux_1by4_seq.
// Directed s-based scenarios run in the default build; the round-robin scenario runs when DEMUX_ROUNDROBIN_EN is defined.
module tb_demux_1by4_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   i;
  logic [1:0]     s;
  logic           i_valid;
  logic           i_ready;
  logic [4*W-1:0] y;
  logic [3:0]     y_valid;
  logic [3:0]     y_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  demux_1by4_seq #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i       (i),
    .s       (s),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; y_ready = 4'h0; s = 2'd0; i = 8'h00;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; s = 2'd0; i = 8'h77; y_ready = 4'h0;
    #1;
    total_cnt++;
    if (i_ready !== 1'b0) $display("FAIL reset_iready got %b exp 0", i_ready); else pass_cnt++;
    cyc(); cyc();
    total_cnt++;
    if (y_valid !== 4'b0000) $display("FAIL reset_yvalid got %b exp 0000", y_valid); else pass_cnt++;
    total_cnt++;
    if (y !== 32'h0000_0000) $display("FAIL reset_y got %h exp 00000000", y); else pass_cnt++;
    i_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    s = 2'd2; i = 8'hA5; i_valid = 1'b1; y_ready = 4'h0;
    #1;
    total_cnt++;
    if (i_ready !== 1'b1) $display("FAIL single_iready got %b exp 1", i_ready); else pass_cnt++;
    cyc();
    i_valid = 1'b0;
    total_cnt++;
    if (y_valid !== 4'b0100) $display("FAIL single_yvalid got %b exp 0100", y_valid); else pass_cnt++;
    total_cnt++;
    if (y !== 32'h00A5_0000) $display("FAIL single_y got %h exp 00a50000", y); else pass_cnt++;
    cyc();
    total_cnt++;
    if (y_valid !== 4'b0100) $display("FAIL single_hold got %b exp 0100", y_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    s = 2'd1; i = 8'h5A; i_valid = 1'b1; y_ready = 4'h0;
    cyc();
    i = 8'hFF;
    #1;
    total_cnt++;
    if (i_ready !== 1'b0) $display("FAIL bp_iready got %b exp 0", i_ready); else pass_cnt++;
    cyc();
    total_cnt++;
    if (y[15:8] !== 8'h5A) $display("FAIL bp_hold_data got %h exp 5a", y[15:8]); else pass_cnt++;
    total_cnt++;
    if (y_valid !== 4'b0010) $display("FAIL bp_hold_valid got %b exp 0010", y_valid); else pass_cnt++;
    i_valid = 1'b0; y_ready = 4'b0010;
    #1;
    total_cnt++;
    if (i_ready !== 1'b1) $display("FAIL bp_release_iready got %b exp 1", i_ready); else pass_cnt++;
    cyc();
    total_cnt++;
    if (y_valid !== 4'b0000) $display("FAIL bp_drain_valid got %b exp 0000", y_valid); else pass_cnt++;
    total_cnt++;
    if (y[15:8] !== 8'h5A) $display("FAIL bp_drain_data got %h exp 5a", y[15:8]); else pass_cnt++;
    y_ready = 4'h0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    s = 2'd0; i = 8'hC3; i_valid = 1'b1; y_ready = 4'h0;
    cyc();
    y_ready = 4'b0001; i = 8'h3C;
    #1;
    total_cnt++;
    if (i_ready !== 1'b1) $display("FAIL b2b_iready got %b exp 1", i_ready); else pass_cnt++;
    cyc();
    total_cnt++;
    if (y_valid !== 4'b0001) $display("FAIL b2b_valid got %b exp 0001", y_valid); else pass_cnt++;
    total_cnt++;
    if (y[7:0] !== 8'h3C) $display("FAIL b2b_data got %h exp 3c", y[7:0]); else pass_cnt++;
    i = 8'h96;
    cyc();
    total_cnt++;
    if (y[7:0] !== 8'h96) $display("FAIL b2b_data2 got %h exp 96", y[7:0]); else pass_cnt++;
    i_valid = 1'b0;
    cyc();
    total_cnt++;
    if (y_valid !== 4'b0000) $display("FAIL b2b_drain got %b exp 0000", y_valid); else pass_cnt++;
    y_ready = 4'h0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      s = 2'(n); i = 8'(8'h11 * (n + 1)); i_valid = 1'b1;
      cyc();
    end
    i_valid = 1'b0;
    total_cnt++;
    if (y !== 32'h4433_2211) $display("FAIL mid_loaded_y got %h exp 44332211", y); else pass_cnt++;
    total_cnt++;
    if (y_valid !== 4'b1111) $display("FAIL mid_loaded_valid got %b exp 1111", y_valid); else pass_cnt++;
    rst = 1'b1; i_valid = 1'b1; s = 2'd2; i = 8'h99;
    #1;
    total_cnt++;
    if (i_ready !== 1'b0) $display("FAIL mid_rst_iready got %b exp 0", i_ready); else pass_cnt++;
    cyc();
    total_cnt++;
    if (y_valid !== 4'b0000) $display("FAIL mid_rst_valid got %b exp 0000", y_valid); else pass_cnt++;
    total_cnt++;
    if (y !== 32'h0000_0000) $display("FAIL mid_rst_y got %h exp 00000000", y); else pass_cnt++;
    rst = 1'b0; s = 2'd0; i = 8'hE7;
    #1;
    total_cnt++;
    if (i_ready !== 1'b1) $display("FAIL mid_after_iready got %b exp 1", i_ready); else pass_cnt++;
    cyc();
    i_valid = 1'b0;
    total_cnt++;
    if (y_valid !== 4'b0001) $display("FAIL mid_after_valid got %b exp 0001", y_valid); else pass_cnt++;
    total_cnt++;
    if (y[7:0] !== 8'hE7) $display("FAIL mid_after_data got %h exp e7", y[7:0]); else pass_cnt++;
  endtask

`ifdef DEMUX_ROUNDROBIN_EN
  task automatic test_roundrobin();
    int ch;
    logic [3:0] exp_v;
    do_reset();
    y_ready = 4'hF;
    for (int k = 0; k < 6; k++) begin
      s = 2'($urandom_range(0, 3)); i = 8'(k + 1); i_valid = 1'b1;
      cyc();
      ch = k % 4;
      exp_v = 4'b0001 << ch;
      total_cnt++;
      if (y_valid !== exp_v) $display("FAIL rr_valid beat %0d got %b exp %b", k, y_valid, exp_v); else pass_cnt++;
      total_cnt++;
      if (y[ch*W +: W] !== 8'(k + 1)) $display("FAIL rr_data beat %0d got %h exp %h", k, y[ch*W +: W], 8'(k + 1)); else pass_cnt++;
    end
    i_valid = 1'b0; y_ready = 4'h0;
  endtask
`endif

  task automatic test_random();
    logic       mf [4];
    logic [7:0] md [4];
    logic [1:0] mptr;
    logic [1:0] msel;
    logic       exp_rdy;
    logic       acc;
    logic [3:0] exp_v;
    do_reset();
    for (int n = 0; n < 4; n++) begin mf[n] = 1'b0; md[n] = 8'h00; end
    mptr = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      s = 2'($urandom_range(0, 3));
      i = 8'($urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      y_ready = 4'($urandom);
      #1;
`ifdef DEMUX_ROUNDROBIN_EN
      msel = mptr;
`else
      msel = s;
`endif
      exp_rdy = !mf[msel] || y_ready[msel];
      exp_v = {mf[3], mf[2], mf[1], mf[0]};
      total_cnt++;
      if (i_ready !== exp_rdy) $display("FAIL rnd_iready cyc %0d got %b exp %b", c, i_ready, exp_rdy); else pass_cnt++;
      total_cnt++;
      if (y_valid !== exp_v) $display("FAIL rnd_valid cyc %0d got %b exp %b", c, y_valid, exp_v); else pass_cnt++;
      for (int n = 0; n < 4; n++) begin
        if (mf[n]) begin
          total_cnt++;
          if (y[n*W +: W] !== md[n]) $display("FAIL rnd_data cyc %0d ch %0d got %h exp %h", c, n, y[n*W +: W], md[n]); else pass_cnt++;
        end
      end
      acc = i_valid && exp_rdy;
      for (int n = 0; n < 4; n++) begin
        if (acc && (msel == 2'(n))) begin
          mf[n] = 1'b1; md[n] = i;
        end else if (mf[n] && y_ready[n]) begin
          mf[n] = 1'b0;
        end
      end
      if (acc) mptr = mptr + 2'd1;
      cyc();
    end
    i_valid = 1'b0; y_ready = 4'h0;
  endtask

  initial begin
    test_reset();
`ifdef DEMUX_ROUNDROBIN_EN
    test_roundrobin();
`else
    test_single_load();
    test_backpressure();
    test_back_to_back();
`endif
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
